lvt_multiport_ram: RTL and testbench
====================================

Name: lvt_multiport_ram

Overview:
- Parametrised NW-write / NR-read multi-port RAM built from 1W1R bank replication plus a register-based Live Value Table (LVT).
- Generalises the fixed 2-port hashed LVT store to arbitrary write and read port counts, depth and width.
- Adds:
  - per-entry valid tracking;
  - deterministic same-address write-collision resolution with a conflict flag;
  - registered read handshake.
- Sits under the hash/key-value engine as its shared value store.

Parameters:
NW, 2, number of write ports (>=1)
NR, 2, number of read ports (>=1)
DATA_W, 32, data width in bits
ADDR_W, 8, address width; DEPTH = 2**ADDR_W entries
SEL_W, $clog2(NW) (min 1), LVT entry select width (derived, localparam)

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
wen  input  NW  per-port write enable
waddr  input  NW*ADDR_W  write addresses, port w at [w*ADDR_W +: ADDR_W]
wdata  input  NW*DATA_W  write data, port w at [w*DATA_W +: DATA_W]
ren  input  NR  per-port read enable
raddr  input  NR*ADDR_W  read addresses, port r at [r*ADDR_W +: ADDR_W]
rdata  output  NR*DATA_W  read data, port r at [r*DATA_W +: DATA_W]
rvalid  output  NR  rdata for port r valid this cycle
wr_conflict  output  NW  port w write was dropped due to a same-address collision (1-cycle pulse)

Behaviour:
- Storage:
  - NW*NR banks bank[w][r], each DEPTH x DATA_W.
  - A write on port w writes bank[w][0..NR-1].
  - Read port r reads bank[0..NW-1][r].
  - Banks are not reset.
- LVT:
  - DEPTH entries of {valid, sel[SEL_W-1:0]}.
  - A successful write on port w to address a sets LVT[a] = {1, w}.
  - reset asynchronously clears every valid bit and sel to 0.
- Write collisions (same cycle, same address, multiple wen):
  - Lowest-index port wins; only it updates its banks and the LVT.
  - Losing ports write nothing.
  - Losing ports pulse wr_conflict[w] = 1 in the following cycle.
  - wr_conflict is 0 otherwise.
- Read handshake:
  - ren[r] sampled at edge E produces rvalid[r] = 1 and rdata[r] for the cycle following E (latency 1).
  - Bank data and LVT entry are captured in the same edge; output mux is driven from the registered LVT select.
  - Captured LVT valid = 0 gives rdata = 0 (never-written address).
  - ren[r] = 0 gives rvalid[r] = 0 next cycle; rdata[r] holds its last value.
- Read/write same address, same cycle:
  - Read returns the pre-write value (read-before-write) unless LVT_BYPASS_EN is defined.
  - A read at edge E+1 or later returns the new value.
- Independent ports:
  - Any combination of NR reads and NW writes is accepted every cycle; no stalls, no backpressure.
- Reset mid-operation:
  - rvalid = 0, wr_conflict = 0, rdata = 0, and all LVT entries invalid, immediately on assertion.
  - In-flight reads are discarded.
  - After deassertion every address reads 0 until written.
- Address wrap: addresses are exactly ADDR_W bits; no out-of-range case exists.

Optional Feature:
- LVT_BYPASS_EN defined:
  - Same-cycle write-to-read forwarding: when ren[r] and a winning write target the same address at edge E, rdata[r] in the next cycle equals that write's wdata.
  - The winner is the lowest-index port, as for collisions.
  - Forwarding is a registered compare per read port.
- LVT_BYPASS_EN undefined:
  - Read-before-write as above.
  - No compare logic is generated.

Test Plan:
- Reset, then ren[0] = 1, raddr = 0x10 -> next cycle rvalid[0] = 1, rdata[0] = 0x00000000.
- Port 0 writes 0xDEADBEEF to 0x10; next cycle ports 0 and 1 both read 0x10 -> both return 0xDEADBEEF one cycle later.
- Port 1 writes 0x11111111 to 0x20, then port 0 writes 0x22222222 to 0x20 in a later cycle -> read of 0x20 returns 0x22222222 (LVT sel = 0).
- Same cycle: port 0 writes 0xAAAA0000 and port 1 writes 0xBBBB0000, both to 0x30 -> wr_conflict = 2'b10 next cycle only; read of 0x30 returns 0xAAAA0000.
- Write 0x5 to 0x40 at edge E and read 0x40 at edge E:
  - Returns the prior value 0x0 without LVT_BYPASS_EN.
  - Returns 0x5 with LVT_BYPASS_EN.
  - A read at E+1 returns 0x5 in both builds.
- Assert reset while rvalid = 1 after writing 0x7 to 0x50 -> rvalid, rdata and wr_conflict go to 0 asynchronously; after release, a read of 0x50 returns 0.

Source files
------------

// File: rtl/lvt_multiport_ram.sv
// lvt_multiport_ram
// -----------------
// NW-write / NR-read multi-port RAM. It is built from NW*NR replicated 1W1R
// banks plus a register-based Live Value Table (LVT). For every address the
// LVT records which write port last wrote it, and whether the address has
// been written since reset. This block is the shared value store under the
// hash/key-value engine.
//
// Optional feature macro: LVT_BYPASS_EN
//   undefined : a read and a write to the same address in the same cycle
//               return the pre-write value (read-before-write).
//   defined   : same-cycle write-to-read forwarding. A registered compare per
//               read port returns the winning write's data.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-high reset
//   wen          [NW]          per-port write enable
//   waddr        [NW*ADDR_W]   write addresses, port w at [w*ADDR_W +: ADDR_W]
//   wdata        [NW*DATA_W]   write data, port w at [w*DATA_W +: DATA_W]
//   ren          [NR]          per-port read enable
//   raddr        [NR*ADDR_W]   read addresses, port r at [r*ADDR_W +: ADDR_W]
//   rdata        [NR*DATA_W]   read data (latency 1), holds when ren was low
//   rvalid       [NR]          rdata for port r is valid this cycle
//   wr_conflict  [NW]          one-cycle pulse: port w write was dropped
module lvt_multiport_ram #(
    parameter int NW     = 2,
    parameter int NR     = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NW-1:0]        wen,
    input  logic [NW*ADDR_W-1:0] waddr,
    input  logic [NW*DATA_W-1:0] wdata,
    input  logic [NR-1:0]        ren,
    input  logic [NR*ADDR_W-1:0] raddr,
    output logic [NR*DATA_W-1:0] rdata,
    output logic [NR-1:0]        rvalid,
    output logic [NW-1:0]        wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SEL_W = (NW > 1) ? $clog2(NW) : 1;

    // beaten_s[w]: a lower-index port writes the same address this cycle
    logic [NW-1:0]           beaten_s;
    logic [NW-1:0]           win_s;

    logic [DEPTH-1:0]        lvt_valid_r;
    logic [SEL_W-1:0]        lvt_sel_r [DEPTH];

    logic [NR-1:0]           rvalid_r;
    logic [NR-1:0]           rd_valid_r;
    logic [NR*SEL_W-1:0]     rd_sel_r;
    logic [NW-1:0]           wr_conflict_r;

    // Bank read registers, flattened as bank (w, r) at [(w*NR+r)*DATA_W +: DATA_W]
    logic [NW*NR*DATA_W-1:0] bank_q_s;

    // Collision detection: the lowest-index enabled port on an address wins
    always_comb begin
        beaten_s = {NW{1'b0}};
        for (int w = 0; w < NW; w++) begin
            for (int j = 0; j < w; j++) begin
                beaten_s[w] = beaten_s[w] |
                    (wen[j] & (waddr[j*ADDR_W +: ADDR_W] == waddr[w*ADDR_W +: ADDR_W]));
            end
        end
    end

    assign win_s = wen & ~beaten_s;

    // LVT update: winners have distinct addresses, so port order does not matter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvt_valid_r <= {DEPTH{1'b0}};
            for (int d = 0; d < DEPTH; d++) begin
                lvt_sel_r[d] <= {SEL_W{1'b0}};
            end
        end else begin
            for (int w = 0; w < NW; w++) begin
                if (win_s[w]) begin
                    lvt_valid_r[waddr[w*ADDR_W +: ADDR_W]] <= 1'b1;
                    lvt_sel_r[waddr[w*ADDR_W +: ADDR_W]]   <= SEL_W'(w);
                end
            end
        end
    end

    // Read handshake and conflict pulse; the LVT entry is captured with the bank data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_r      <= {NR{1'b0}};
            rd_valid_r    <= {NR{1'b0}};
            rd_sel_r      <= {(NR*SEL_W){1'b0}};
            wr_conflict_r <= {NW{1'b0}};
        end else begin
            rvalid_r      <= ren;
            wr_conflict_r <= wen & beaten_s;
            for (int r = 0; r < NR; r++) begin
                if (ren[r]) begin
                    rd_valid_r[r]                <= lvt_valid_r[raddr[r*ADDR_W +: ADDR_W]];
                    rd_sel_r[r*SEL_W +: SEL_W]   <= lvt_sel_r[raddr[r*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    // Bank (w, r) is written only by port w and read only by port r
    for (genvar gw = 0; gw < NW; gw++) begin : g_wr
        for (genvar gr = 0; gr < NR; gr++) begin : g_rd
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] q_r;

            // Bank write from its owning write port (banks are not reset)
            always_ff @(posedge clk) begin
                if (win_s[gw]) begin
                    mem[waddr[gw*ADDR_W +: ADDR_W]] <= wdata[gw*DATA_W +: DATA_W];
                end
            end

            // Bank read register; holds its value while the read port is idle
            always_ff @(posedge clk) begin
                if (ren[gr]) begin
                    q_r <= mem[raddr[gr*ADDR_W +: ADDR_W]];
                end
            end

            assign bank_q_s[(gw*NR+gr)*DATA_W +: DATA_W] = q_r;
        end
    end

`ifdef LVT_BYPASS_EN
    logic [NR-1:0]        byp_hit_s;
    logic [NR*DATA_W-1:0] byp_data_s;
    logic [NR-1:0]        byp_hit_r;
    logic [NR*DATA_W-1:0] byp_data_r;

    // Forwarding compare: iterating downward leaves the lowest-index (winning) match
    always_comb begin
        byp_hit_s  = {NR{1'b0}};
        byp_data_s = {(NR*DATA_W){1'b0}};
        for (int r = 0; r < NR; r++) begin
            for (int w = NW - 1; w >= 0; w--) begin
                if (win_s[w] && (waddr[w*ADDR_W +: ADDR_W] == raddr[r*ADDR_W +: ADDR_W])) begin
                    byp_hit_s[r]                  = 1'b1;
                    byp_data_s[r*DATA_W +: DATA_W] = wdata[w*DATA_W +: DATA_W];
                end else begin
                    byp_hit_s[r]                  = byp_hit_s[r];
                    byp_data_s[r*DATA_W +: DATA_W] = byp_data_s[r*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Forwarding registers, captured alongside the bank read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_hit_r  <= {NR{1'b0}};
            byp_data_r <= {(NR*DATA_W){1'b0}};
        end else begin
            for (int r = 0; r < NR; r++) begin
                if (ren[r]) begin
                    byp_hit_r[r]                  <= byp_hit_s[r];
                    byp_data_r[r*DATA_W +: DATA_W] <= byp_data_s[r*DATA_W +: DATA_W];
                end
            end
        end
    end
`endif

    // Output mux from the registered LVT select; never-written address reads 0
    always_comb begin
        rdata = {(NR*DATA_W){1'b0}};
        for (int r = 0; r < NR; r++) begin
            for (int w = 0; w < NW; w++) begin
                if (rd_valid_r[r] && (rd_sel_r[r*SEL_W +: SEL_W] == SEL_W'(w))) begin
                    rdata[r*DATA_W +: DATA_W] = bank_q_s[(w*NR+r)*DATA_W +: DATA_W];
                end else begin
                    rdata[r*DATA_W +: DATA_W] = rdata[r*DATA_W +: DATA_W];
                end
            end
`ifdef LVT_BYPASS_EN
            if (byp_hit_r[r]) begin
                rdata[r*DATA_W +: DATA_W] = byp_data_r[r*DATA_W +: DATA_W];
            end else begin
                rdata[r*DATA_W +: DATA_W] = rdata[r*DATA_W +: DATA_W];
            end
`endif
        end
    end

    assign rvalid      = rvalid_r;
    assign wr_conflict = wr_conflict_r;

endmodule

// File: tb/tb_lvt_multiport_ram.sv
module tb_lvt_multiport_ram;

    localparam int NW     = 2;
    localparam int NR     = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic                 clk;
    logic                 reset;
    logic [NW-1:0]        wen;
    logic [NW*ADDR_W-1:0] waddr;
    logic [NW*DATA_W-1:0] wdata;
    logic [NR-1:0]        ren;
    logic [NR*ADDR_W-1:0] raddr;
    logic [NR*DATA_W-1:0] rdata;
    logic [NR-1:0]        rvalid;
    logic [NW-1:0]        wr_conflict;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: plain memory image plus a "written since reset" flag
    logic [DATA_W-1:0] mem_m     [DEPTH];
    bit                written_m [DEPTH];
    logic [DATA_W-1:0] last_rd_m [NR];

    lvt_multiport_ram #(
        .NW(NW), .NR(NR), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wen(wen),
        .waddr(waddr),
        .wdata(wdata),
        .ren(ren),
        .raddr(raddr),
        .rdata(rdata),
        .rvalid(rvalid),
        .wr_conflict(wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a]     = '0;
            written_m[a] = 1'b0;
        end
        for (int r = 0; r < NR; r++) last_rd_m[r] = '0;
    endtask

    // One cycle: drive at the falling edge, check 1 time unit after the rising edge
    task automatic step(input string tag,
                        input logic [NW-1:0] we, input logic [NW*ADDR_W-1:0] wa,
                        input logic [NW*DATA_W-1:0] wd,
                        input logic [NR-1:0] re, input logic [NR*ADDR_W-1:0] ra);
        logic [NW-1:0] exp_conf;
        logic [ADDR_W-1:0] a_r;
        logic [DATA_W-1:0] v;
        wen = we; waddr = wa; wdata = wd; ren = re; raddr = ra;
        for (int r = 0; r < NR; r++) begin
            if (re[r]) begin
                a_r = ra[r*ADDR_W +: ADDR_W];
                v = written_m[a_r] ? mem_m[a_r] : '0;
`ifdef LVT_BYPASS_EN
                for (int w = NW - 1; w >= 0; w--) begin
                    if (we[w] && wa[w*ADDR_W +: ADDR_W] == a_r) v = wd[w*DATA_W +: DATA_W];
                end
`endif
                last_rd_m[r] = v;
            end
        end
        exp_conf = '0;
        for (int w = 0; w < NW; w++) begin
            for (int j = 0; j < w; j++) begin
                if (we[j] && we[w] && wa[j*ADDR_W +: ADDR_W] == wa[w*ADDR_W +: ADDR_W])
                    exp_conf[w] = 1'b1;
            end
        end
        // Apply writes highest port first so the lowest port lands last and wins
        for (int w = NW - 1; w >= 0; w--) begin
            if (we[w]) begin
                mem_m[wa[w*ADDR_W +: ADDR_W]]     = wd[w*DATA_W +: DATA_W];
                written_m[wa[w*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".rvalid"}, 64'(rvalid), 64'(re));
        chk({tag, ".conflict"}, 64'(wr_conflict), 64'(exp_conf));
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("%s.rdata%0d", tag, r), 64'(rdata[r*DATA_W +: DATA_W]), 64'(last_rd_m[r]));
        end
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, ".rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, ".conflict"}, 64'(wr_conflict), 64'd0);
        chk({tag, ".rdata"}, 64'(rdata), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        wen = '0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;

        // Never-written address reads 0
        step("rd_unwritten", 2'b00, 16'h0000, 64'h0, 2'b01, 16'h0010);
        // Write then dual read
        step("wr_10", 2'b01, 16'h0010, 64'h00000000_DEADBEEF, 2'b00, 16'h0000);
        step("rd_10_both", 2'b00, 16'h0000, 64'h0, 2'b11, 16'h1010);
        // Later write from a lower port overrides
        step("wr_20_p1", 2'b10, 16'h2000, 64'h11111111_00000000, 2'b00, 16'h0000);
        step("wr_20_p0", 2'b01, 16'h0020, 64'h00000000_22222222, 2'b00, 16'h0000);
        step("rd_20", 2'b00, 16'h0000, 64'h0, 2'b11, 16'h2020);
        // Same-cycle collision: port 0 wins, conflict pulses for one cycle only
        step("coll_30", 2'b11, 16'h3030, 64'hBBBB0000_AAAA0000, 2'b00, 16'h0000);
        step("coll_30_after", 2'b00, 16'h0000, 64'h0, 2'b00, 16'h0000);
        step("rd_30", 2'b00, 16'h0000, 64'h0, 2'b10, 16'h3000);
        // Read and write the same address in the same cycle, then read again
        step("rw_40", 2'b01, 16'h0040, 64'h00000000_00000005, 2'b01, 16'h0040);
        step("rd_40", 2'b00, 16'h0000, 64'h0, 2'b11, 16'h4040);
        // Reset in mid-operation while rvalid and wr_conflict are high
        step("wr_50", 2'b01, 16'h0050, 64'h00000000_00000007, 2'b00, 16'h0000);
        step("rd_50_coll", 2'b11, 16'h6060, 64'h12345678_9ABCDEF0, 2'b11, 16'h5050);
        wen = '0; ren = '0;
        reset = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step("rd_50_post_reset", 2'b00, 16'h0000, 64'h0, 2'b11, 16'h5050);

        // Randomized traffic on a small address window to force collisions
        for (int i = 0; i < 400; i++) begin
            logic [NW*ADDR_W-1:0] wa;
            logic [NR*ADDR_W-1:0] ra;
            logic [NW*DATA_W-1:0] wd;
            for (int w = 0; w < NW; w++) begin
                wa[w*ADDR_W +: ADDR_W] = 8'h80 + 8'($urandom_range(0, 3));
                wd[w*DATA_W +: DATA_W] = $urandom;
            end
            for (int r = 0; r < NR; r++) ra[r*ADDR_W +: ADDR_W] = 8'h80 + 8'($urandom_range(0, 4));
            step($sformatf("rnd%0d", i), NW'($urandom), wa, wd, NR'($urandom), ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
